// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the EX-stage operand controller:
// opcodes, ALU op codes, rs2 mux selects, occupancy states, decoded control word.
package alu_ctrl_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_COPY_A = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    SEL_RS2   = 2'd0,
    SEL_IMM_I = 2'd1,
    SEL_IMM_S = 2'd2,
    SEL_PC    = 2'd3
  } sel_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  typedef struct packed {
    logic    illegal;
    sel_e    sel;
    alu_op_e alu_op;
    logic    rd_wen;
  } ctrl_t;

  // funct3 -> ALU op for the register/immediate arithmetic groups (no SUB/SRA here).
  function automatic alu_op_e f3_to_op(input logic [2:0] f3);
    case (f3)
      3'b000:  f3_to_op = ALU_ADD;
      3'b001:  f3_to_op = ALU_SLL;
      3'b010:  f3_to_op = ALU_SLT;
      3'b011:  f3_to_op = ALU_SLTU;
      3'b100:  f3_to_op = ALU_XOR;
      3'b101:  f3_to_op = ALU_SRL;
      3'b110:  f3_to_op = ALU_OR;
      default: f3_to_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational RV32I decode of the B-operand select, ALU op, rd write enable
// and illegal flag. Illegal words decode to a harmless ADD with no writeback.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] f3_i,
  input  logic [6:0] f7_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o.illegal = 1'b0;
    ctrl_o.sel     = SEL_RS2;
    ctrl_o.alu_op  = ALU_ADD;
    ctrl_o.rd_wen  = 1'b1;
    case (opcode_i)
      OPC_OP: begin
        if (f7_i == 7'b0000000) begin
          ctrl_o.alu_op = f3_to_op(f3_i);
        end else if (f7_i == 7'b0100000 && f3_i == 3'b000) begin
          ctrl_o.alu_op = ALU_SUB;
        end else if (f7_i == 7'b0100000 && f3_i == 3'b101) begin
          ctrl_o.alu_op = ALU_SRA;
        end else begin
          ctrl_o.illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        ctrl_o.sel    = SEL_IMM_I;
        ctrl_o.alu_op = (f3_i == 3'b101 && f7_i[5]) ? ALU_SRA : f3_to_op(f3_i);
      end
      OPC_LOAD, OPC_JALR: ctrl_o.sel = SEL_IMM_I;
      OPC_STORE: begin
        ctrl_o.sel    = SEL_IMM_S;
        ctrl_o.rd_wen = 1'b0;
      end
      OPC_AUIPC, OPC_JAL: ctrl_o.sel = SEL_PC;
      OPC_BRANCH: begin
        ctrl_o.alu_op = ALU_SUB;
        ctrl_o.rd_wen = 1'b0;
      end
      OPC_LUI: begin
        ctrl_o.sel    = SEL_IMM_I;
        ctrl_o.alu_op = ALU_COPY_A;
      end
      default: ctrl_o.illegal = 1'b1;
    endcase
    // Opcode list above only holds 11-quadrant words, so the default covers inst[1:0]!=11.
    if (ctrl_o.illegal) begin
      ctrl_o.sel    = SEL_RS2;
      ctrl_o.alu_op = ALU_ADD;
      ctrl_o.rd_wen = 1'b0;
    end
  end

endmodule

// File: rtl/alu_operand_ctrl.sv
// EX-stage operand controller: decodes the incoming instruction into a
// 2-entry head/skid buffer and counts legal instructions taken by EX.
module alu_operand_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int COUNT_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               io_in_valid,
  output logic               io_in_ready,
  input  logic [XLEN-1:0]    io_inst,
  input  logic               io_flush,
  output logic               io_out_valid,
  input  logic               io_out_ready,
  output logic [1:0]         io_rs2_mux_sel,
  output logic [3:0]         io_alu_op,
  output logic               io_rd_wen,
  output logic               io_illegal,
  output logic [COUNT_W-1:0] io_issue_count
);

  occ_e               state_q, state_d;
  ctrl_t              head_q, head_d;
  ctrl_t              skid_q, skid_d;
  ctrl_t              dec;
  logic [COUNT_W-1:0] issue_cnt_q;
  logic               accept, issue;
  logic               unused_inst;

  alu_ctrl_decode u_dec (
    .opcode_i (io_inst[6:0]),
    .f3_i     (io_inst[14:12]),
    .f7_i     (io_inst[31:25]),
    .ctrl_o   (dec)
  );

  assign unused_inst = ^{io_inst[24:15], io_inst[11:7]};

  assign io_in_ready    = (state_q != TWO);
  assign io_out_valid   = (state_q != EMPTY);
  assign io_rs2_mux_sel = head_q.sel;
  assign io_alu_op      = head_q.alu_op;
  assign io_rd_wen      = head_q.rd_wen;
  assign io_illegal     = head_q.illegal;
  assign io_issue_count = issue_cnt_q;

  assign accept = io_in_valid && io_in_ready;
  assign issue  = io_out_valid && io_out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (io_flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          head_d  = dec;
          state_d = ONE;
        end
        ONE: begin
          if (accept && issue) begin
            head_d = dec;
          end else if (accept) begin
            skid_d  = dec;
            state_d = TWO;
          end else if (issue) begin
            state_d = EMPTY;
          end
        end
        TWO: if (issue) begin
          head_d  = skid_q;
          state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  // A flushed-away head still counts if EX took it in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      issue_cnt_q <= '0;
    end else if (issue && !head_q.illegal) begin
      issue_cnt_q <= issue_cnt_q + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_operand_ctrl.sv
// Randomized + directed bench for alu_operand_ctrl against a queue-based model.
module tb_alu_operand_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_in_valid, io_in_ready, io_flush, io_out_valid, io_out_ready;
  logic [31:0] io_inst;
  logic [1:0]  io_rs2_mux_sel;
  logic [3:0]  io_alu_op;
  logic        io_rd_wen, io_illegal;
  logic [31:0] io_issue_count;

  int errs = 0;
  int checks = 0;

  alu_operand_ctrl #(.XLEN(32), .COUNT_W(32)) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready), .io_inst(io_inst),
    .io_flush(io_flush), .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_rs2_mux_sel(io_rs2_mux_sel), .io_alu_op(io_alu_op), .io_rd_wen(io_rd_wen),
    .io_illegal(io_illegal), .io_issue_count(io_issue_count)
  );

  always #5 clock = ~clock;

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_ADDI  = 32'h00508093;
  localparam logic [31:0] I_SW    = 32'h0020A223;
  localparam logic [31:0] I_AUIPC = 32'h00001097;
  localparam logic [31:0] I_SUB   = 32'h40208133;
  localparam logic [31:0] I_SRAI  = 32'h4050D093;
  localparam logic [31:0] I_MUL   = 32'h022081B3;

  localparam int F3OP [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
  localparam logic [6:0] OPCS [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h17, 7'h6F, 7'h63, 7'h37};

  typedef struct { bit ill; int sel; int op; bit wen; } exp_t;

  exp_t        q[$];
  logic [31:0] mcount = 0;

  function automatic exp_t ref_dec(logic [31:0] w);
    exp_t e = '{1'b1, 0, 0, 1'b0};
    if (w[1:0] != 2'b11) return e;
    case (w[6:0])
      7'h33: begin
        if (w[31:25] == 7'h00)                         e = '{1'b0, 0, F3OP[w[14:12]], 1'b1};
        else if (w[31:25] == 7'h20 && w[14:12] == 3'd0) e = '{1'b0, 0, 1, 1'b1};
        else if (w[31:25] == 7'h20 && w[14:12] == 3'd5) e = '{1'b0, 0, 7, 1'b1};
      end
      7'h13: e = '{1'b0, 1, (w[14:12] == 3'd5 && w[30]) ? 7 : F3OP[w[14:12]], 1'b1};
      7'h03, 7'h67: e = '{1'b0, 1, 0, 1'b1};
      7'h23:        e = '{1'b0, 2, 0, 1'b0};
      7'h17, 7'h6F: e = '{1'b0, 3, 0, 1'b1};
      7'h63:        e = '{1'b0, 0, 1, 1'b0};
      7'h37:        e = '{1'b0, 1, 10, 1'b1};
      default: ;
    endcase
    return e;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: at most two entries, strict FIFO, flush empties, issue of a legal head counts.
  always @(posedge clock) begin : model
    bit acc, iss;
    if (reset) begin
      acc = io_in_valid && (q.size() < 2);
      iss = (q.size() > 0) && io_out_ready;
      if (iss && !q[0].ill) mcount = mcount + 1;
      if (io_flush) q.delete();
      else begin
        if (iss) void'(q.pop_front());
        if (acc) q.push_back(ref_dec(io_inst));
      end
    end
  end

  always @(negedge reset) begin
    q.delete();
    mcount = 0;
  end

  always @(negedge clock) begin
    if (reset) begin
      chk("out_valid", io_out_valid, q.size() > 0);
      chk("in_ready", io_in_ready, q.size() < 2);
      chk("count", io_issue_count, mcount);
      if (q.size() > 0) begin
        chk("sel", io_rs2_mux_sel, q[0].sel);
        chk("alu_op", io_alu_op, q[0].op);
        chk("rd_wen", io_rd_wen, q[0].wen);
        chk("illegal", io_illegal, q[0].ill);
      end
    end
  end

  task automatic step(bit v, logic [31:0] w, bit r, bit f);
    io_in_valid = v; io_inst = w; io_out_ready = r; io_flush = f;
    @(posedge clock); #1;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] w = $urandom;
    if ($urandom_range(0, 9) < 8) begin
      w[6:0] = OPCS[$urandom_range(0, 8)];
      if (w[6:0] == 7'h33 && $urandom_range(0, 1) == 1)
        w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    end
    return w;
  endfunction

  task automatic chk_out(string nm, int sel, int op, bit wen, bit ill);
    chk({nm, ".sel"}, io_rs2_mux_sel, sel);
    chk({nm, ".op"}, io_alu_op, op);
    chk({nm, ".wen"}, io_rd_wen, wen);
    chk({nm, ".ill"}, io_illegal, ill);
  endtask

  initial begin
    io_in_valid = 0; io_inst = 0; io_out_ready = 0; io_flush = 0;
    #3;
    chk("rst.valid", io_out_valid, 0);
    chk("rst.ready", io_in_ready, 1);
    chk("rst.count", io_issue_count, 0);
    chk_out("rst", 0, 0, 0, 0);
    @(posedge clock); #1;
    reset = 1;

    // stream
    step(1, I_ADD, 1, 0);   chk_out("add", 0, 0, 1, 0);
    step(1, I_ADDI, 1, 0);  chk_out("addi", 1, 0, 1, 0);
    step(1, I_SW, 1, 0);    chk_out("sw", 2, 0, 0, 0);
    step(1, I_AUIPC, 1, 0); chk_out("auipc", 3, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("stream.count", io_issue_count, 4);
    chk("stream.valid", io_out_valid, 0);

    // decode corners
    step(1, I_SUB, 0, 0);  chk_out("sub", 0, 1, 1, 0);
    step(0, 0, 1, 0);
    step(1, I_SRAI, 1, 0); chk_out("srai", 1, 7, 1, 0);
    step(1, I_MUL, 1, 0);  chk_out("mul", 0, 0, 0, 1);
    step(0, 0, 1, 0);
    chk("illegal.count", io_issue_count, 6);

    // backpressure
    step(1, I_ADD, 0, 0);  chk("bp.ready1", io_in_ready, 1);
    step(1, I_SUB, 0, 0);  chk("bp.ready2", io_in_ready, 0); chk("bp.head0", io_alu_op, 0);
    step(1, I_SRAI, 0, 0); chk("bp.ready3", io_in_ready, 0); chk("bp.head1", io_alu_op, 0);
    step(1, I_SRAI, 1, 0); chk("bp.head2", io_alu_op, 1); chk("bp.ready4", io_in_ready, 1);
    step(1, I_SRAI, 1, 0); chk("bp.head3", io_alu_op, 7);
    step(0, 0, 1, 0);
    chk("bp.valid", io_out_valid, 0);
    chk("bp.count", io_issue_count, 9);

    // flush while full
    step(1, I_ADD, 0, 0);
    step(1, I_ADDI, 0, 0); chk("fl.full", io_in_ready, 0);
    step(1, I_SUB, 0, 1);
    chk("fl.valid", io_out_valid, 0);
    chk("fl.ready", io_in_ready, 1);
    chk("fl.count", io_issue_count, 9);
    step(0, 0, 0, 0);      chk("fl.dropped", io_out_valid, 0);

    // async reset while TWO
    step(1, I_ADD, 0, 0);
    step(1, I_ADDI, 0, 0);
    io_in_valid = 0;
    #2 reset = 0;
    #1;
    chk("arst.valid", io_out_valid, 0);
    chk("arst.ready", io_in_ready, 1);
    chk("arst.count", io_issue_count, 0);
    chk_out("arst", 0, 0, 0, 0);
    @(posedge clock); #1;
    reset = 1;

    // random
    repeat (400) step($urandom_range(0, 3) != 0, pick(), $urandom_range(0, 3) != 0,
                      $urandom_range(0, 19) == 0);

    // counter wrap
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    force dut.issue_cnt_q = 32'hFFFF_FFFF;
    mcount = 32'hFFFF_FFFF;
    #1 release dut.issue_cnt_q;
    chk("wrap.pre", io_issue_count, 32'hFFFF_FFFF);
    step(1, I_ADD, 1, 0);
    step(0, 0, 1, 0);
    chk("wrap.count", io_issue_count, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
